// File: rtl/text_cell_sequencer.sv
// Character-overlay sequencer for the VGA text layer.
// Turns the scan position into character-cell coordinates, latches the
// character owning each cell, addresses the glyph ROM and picks the pixel
// bit. Syncs are delayed by the same three ticks as the pixel. The
// displayed data words are snapshotted once per frame at vertical-blank
// start.
module text_cell_sequencer #(
  parameter int NWORDS      = 4,
  parameter int VBLANK_LINE = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pixel_en,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  video_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  freeze,
  input  logic [16*NWORDS-1:0]  data_in,
  input  logic                  char_p_in,
  input  logic [7:0]            char_in,
  input  logic [7:0]            rom_data,
  output logic [4:0]            row,
  output logic [6:0]            col,
  output logic                  enable,
  output logic [16*NWORDS-1:0]  data_out,
  output logic [11:0]           rom_addr,
  output logic                  pixel_on,
  output logic                  video_on_out,
  output logic                  hsync_out,
  output logic                  vsync_out
);

  localparam logic [9:0] VBLANK_V  = 10'(VBLANK_LINE);
  localparam logic [9:0] VISIBLE_V = 10'd480;

  // Stage-0 copies not broadcast to the string generators.
  logic [3:0] line0;
  logic [2:0] bit0;
  logic       vid0;
  logic       hs0;
  logic       vs0;

  // Stage-1 state.
  logic [7:0] char1;
  logic [2:0] bit1;
  logic       enable1;
  logic       vid1;
  logic       hs1;
  logic       vs1;

  // Stage 0: decode the scan position into cell coordinates and sub-cell offsets.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: all state uses non-blocking assignments so every stage reads the
      // previous tick's values of the stage before it, giving a true pipeline.
      row    <= '0;
      col    <= '0;
      enable <= 1'b0;
      line0  <= '0;
      bit0   <= '0;
      vid0   <= 1'b0;
      hs0    <= 1'b0;
      vs0    <= 1'b0;
    end else if (pixel_en) begin
      row    <= vcount[8:4];
      col    <= hcount[9:3];
      enable <= video_on && (vcount < VISIBLE_V);
      line0  <= vcount[3:0];
      bit0   <= hcount[2:0];
      vid0   <= video_on;
      hs0    <= hsync_in;
      vs0    <= vsync_in;
    end
  end

  // Stage 1: latch the cell's character off the wired-OR bus and address the glyph ROM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      char1    <= '0;
      rom_addr <= '0;
      bit1     <= '0;
      enable1  <= 1'b0;
      vid1     <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
    end else if (pixel_en) begin
      char1    <= char_p_in ? char_in : 8'h00;
      rom_addr <= {(char_p_in ? char_in : 8'h00), line0};
      bit1     <= bit0;
      enable1  <= enable;
      vid1     <= vid0;
      hs1      <= hs0;
      vs1      <= vs0;
    end
  end

  // Stage 2: select the glyph bit (MSB is the leftmost pixel) and emit aligned syncs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pixel_on     <= 1'b0;
      video_on_out <= 1'b0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
    end else if (pixel_en) begin
      pixel_on     <= enable1 && (char1 != 8'h00) && rom_data[3'd7 - bit1];
      video_on_out <= vid1;
      hsync_out    <= hs1;
      vsync_out    <= vs1;
    end
  end

  // Snapshot the live data words once per frame so the display never tears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (pixel_en && (vcount == VBLANK_V) && (hcount == 10'd0) && !freeze) begin
      data_out <= data_in;
    end
  end

endmodule

// File: tb/tb_text_cell_sequencer.sv
// Self-checking bench for text_cell_sequencer: table of steady-state cell
// vectors plus hand sequences for latency, sync alignment and snapshot.
module tb_text_cell_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        freeze;
  logic [63:0] data_in;
  logic        char_p_in;
  logic [7:0]  char_in;
  logic [7:0]  rom_data;
  logic [4:0]  row;
  logic [6:0]  col;
  logic        enable;
  logic [63:0] data_out;
  logic [11:0] rom_addr;
  logic        pixel_on;
  logic        video_on_out;
  logic        hsync_out;
  logic        vsync_out;

  // String-generator and ROM model controls.
  logic        str_en;
  logic        junk;
  logic [7:0]  rom_def;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [63:0] exp_data;

  text_cell_sequencer #(.NWORDS(4), .VBLANK_LINE(480)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .freeze(freeze),
    .data_in(data_in), .char_p_in(char_p_in), .char_in(char_in),
    .rom_data(rom_data), .row(row), .col(col), .enable(enable),
    .data_out(data_out), .rom_addr(rom_addr), .pixel_on(pixel_on),
    .video_on_out(video_on_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // One string owning row 3 col 5 with "A"; junk puts a code on the bus with no owner.
  always_comb begin
    char_p_in = str_en && enable && (row == 5'd3) && (col == 7'd5);
    char_in   = (char_p_in || junk) ? 8'h41 : 8'h00;
  end

  // Synchronous glyph ROM, one clk latency.
  always @(posedge clk) begin
    rom_data <= (rom_addr == 12'h415) ? 8'b0001_0000 : rom_def;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One pixel_en tick followed by gap idle clocks; returns #1 after an edge.
  task automatic tick(input int gap);
    pixel_en = 1'b1;
    @(posedge clk); #1;
    pixel_en = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_pos(input logic [9:0] h, input logic [9:0] v, input logic vid);
    hcount   = h;
    vcount   = v;
    video_on = vid;
  endtask

  // Compressed frame sweep: four columns per line, snapshot model alongside.
  task automatic sweep_frame(input logic frz, input int change_v, input logic [63:0] new_data);
    int bad = 0;
    logic [9:0] h;
    freeze = frz;
    for (int v = 0; v < 525; v++) begin
      for (int hi = 0; hi < 4; hi++) begin
        case (hi)
          0: h = 10'd0;
          1: h = 10'd1;
          2: h = 10'd400;
          default: h = 10'd799;
        endcase
        if (v == change_v && hi == 0) data_in = new_data;
        set_pos(h, 10'(v), (h < 10'd640) && (v < 480));
        if (v == 480 && h == 10'd0 && !frz) exp_data = data_in;
        tick(0);
        if (data_out !== exp_data) bad++;
        if (v == 480 && hi == 0) check("snap_at_480", data_out, exp_data);
      end
    end
    check("snap_frame_hold", 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        vid;
    logic        str;
    logic        junk;
    logic [7:0]  def;
    logic [4:0]  row;
    logic [6:0]  col;
    logic        en;
    logic [11:0] addr;
    logic        pix;
    logic        vout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{10'd43,  10'd53,  1'b1, 1'b1, 1'b0, 8'h00, 5'd3,  7'd5,  1'b1, 12'h415, 1'b1, 1'b1};
    vecs[1] = '{10'd42,  10'd53,  1'b1, 1'b1, 1'b0, 8'h00, 5'd3,  7'd5,  1'b1, 12'h415, 1'b0, 1'b1};
    vecs[2] = '{10'd43,  10'd53,  1'b1, 1'b0, 1'b1, 8'hFF, 5'd3,  7'd5,  1'b1, 12'h005, 1'b0, 1'b1};
    vecs[3] = '{10'd0,   10'd490, 1'b0, 1'b1, 1'b0, 8'hFF, 5'd30, 7'd0,  1'b0, 12'h00A, 1'b0, 1'b0};
    vecs[4] = '{10'd43,  10'd485, 1'b1, 1'b1, 1'b0, 8'hFF, 5'd30, 7'd5,  1'b0, 12'h005, 1'b0, 1'b1};
    vecs[5] = '{10'd47,  10'd63,  1'b1, 1'b1, 1'b0, 8'hFF, 5'd3,  7'd5,  1'b1, 12'h41F, 1'b1, 1'b1};
    vecs[6] = '{10'd799, 10'd524, 1'b0, 1'b1, 1'b0, 8'hFF, 5'd0,  7'd99, 1'b0, 12'h00C, 1'b0, 1'b0};
    vecs[7] = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b0, 8'hFF, 5'd29, 7'd79, 1'b1, 12'h00F, 1'b0, 1'b1};

    // Reset held 3 clk with pixel_en high and busy inputs, at the snapshot point.
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    set_pos(10'd0, 10'd480, 1'b1);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    freeze   = 1'b0;
    data_in  = 64'hDEAD_BEEF_0BAD_F00D;
    str_en   = 1'b1;
    junk     = 1'b0;
    rom_def  = 8'hFF;
    exp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {38'd0, row, col, enable, rom_addr, pixel_on, video_on_out, hsync_out, vsync_out},
          64'd0);
    check("reset_data_out", data_out, 64'd0);
    reset_n  = 1'b1;
    pixel_en = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // Steady-state cell vectors: position held long enough to fill the pipe and ROM.
    foreach (vecs[i]) begin
      set_pos(vecs[i].h, vecs[i].v, vecs[i].vid);
      str_en  = vecs[i].str;
      junk    = vecs[i].junk;
      rom_def = vecs[i].def;
      repeat (4) tick(0);
      check($sformatf("vec%0d_row", i),  64'(row),          64'(vecs[i].row));
      check($sformatf("vec%0d_col", i),  64'(col),          64'(vecs[i].col));
      check($sformatf("vec%0d_en", i),   64'(enable),       64'(vecs[i].en));
      check($sformatf("vec%0d_addr", i), 64'(rom_addr),     64'(vecs[i].addr));
      check($sformatf("vec%0d_pix", i),  64'(pixel_on),     64'(vecs[i].pix));
      check($sformatf("vec%0d_vout", i), 64'(video_on_out), 64'(vecs[i].vout));
    end

    // Pixel latency: (43,53) presented for exactly one tick, pixel_en every 2nd clk.
    str_en  = 1'b1;
    junk    = 1'b0;
    rom_def = 8'hFF;
    set_pos(10'd43, 10'd53, 1'b1);
    tick(1);
    check("lat_row", 64'(row), 64'd3);
    check("lat_col", 64'(col), 64'd5);
    check("lat_en",  64'(enable), 64'd1);
    set_pos(10'd0, 10'd490, 1'b0);
    tick(1);
    check("lat_addr", 64'(rom_addr), 64'h415);
    check("lat_pix_t2", 64'(pixel_on), 64'd0);
    tick(1);
    check("lat_pix_t3", 64'(pixel_on), 64'd1);
    tick(1);
    check("lat_pix_t4", 64'(pixel_on), 64'd0);

    // Sync alignment: one-tick pulse must appear exactly 3 ticks later.
    for (int gap = 0; gap < 2; gap++) begin
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      repeat (3) tick(gap);
      for (int k = 1; k <= 4; k++) begin
        hsync_in = (k == 1);
        vsync_in = (k == 1);
        tick(gap);
        check($sformatf("sync_gap%0d_t%0d", gap, k),
              64'({hsync_out, vsync_out}), (k == 3) ? 64'd3 : 64'd0);
      end
    end

    // Snapshot frames: plain update, mid-frame change, then frozen.
    sweep_frame(1'b0, 0,   64'hC3C3_0F0F_5A5A_96A5);
    check("snap_f1_word0", 64'(data_out[15:0]), 64'h96A5);
    sweep_frame(1'b0, 200, 64'h4444_3333_2222_1234);
    check("snap_f2_word0", 64'(data_out[15:0]), 64'h1234);
    sweep_frame(1'b1, 100, 64'h7777_8888_9999_AAAA);
    check("snap_frozen", data_out, 64'h4444_3333_2222_1234);

    // Freeze rising on the snapshot tick itself, then hcount past 0.
    freeze  = 1'b0;
    data_in = 64'h0101_0202_0303_0404;
    set_pos(10'd799, 10'd479, 1'b0);
    tick(0);
    freeze = 1'b1;
    set_pos(10'd0, 10'd480, 1'b0);
    tick(0);
    check("snap_freeze_edge", data_out, exp_data);
    freeze = 1'b0;
    set_pos(10'd1, 10'd480, 1'b0);
    tick(0);
    check("snap_h1_no_update", data_out, exp_data);

    // pixel_en low at the snapshot point: nothing moves.
    set_pos(10'd0, 10'd480, 1'b0);
    pixel_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("snap_pixel_en_low", data_out, exp_data);

    // Reset and snapshot in the same clk: reset wins.
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    @(posedge clk); #1;
    exp_data = '0;
    check("reset_beats_snap", data_out, exp_data);
    reset_n  = 1'b1;
    pixel_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
